// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared constants for the fetch-stage PC sequencer: FSM state
//                encoding, redirect-kind codes, address width and PC step.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // Sequencer FSM states
    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_DELIVER = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    // Redirect kinds presented by decode
    localparam logic [1:0] BR   = 2'b00;
    localparam logic [1:0] J    = 2'b01;
    localparam logic [1:0] JR   = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    // Address of the instruction that follows pc (wraps modulo 2^32)
    function automatic logic [ADDR_W-1:0] next_seq(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC selection for the fetch sequencer.
//                Produces the sequential PC and the redirect-applied PC, plus
//                a flag for a taken jr whose target is not word aligned.
//                Optional feature macro: PC_SEQUENCER_MISALIGN_TRAP_EN
//                (misaligned jr goes to TRAP_VECTOR and raises jr_trap).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import pc_sequencer_pkg::*;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
#(
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 32'h0000_0080
)
`endif
(
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [15:0]       branch_imm,
    input  logic [25:0]       jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] seq_pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              jr_trap
);

    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] jr_pc;

    assign seq_pc     = next_seq(fetch_pc);
    // Word offset, sign-extended and scaled to bytes
    assign branch_off = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    logic jr_misaligned;
    assign jr_misaligned = |jr_target[1:0];
    assign jr_pc         = jr_misaligned ? TRAP_VECTOR : jr_target;
    assign jr_trap       = redirect_valid && (redirect_kind == JR) && jr_misaligned;
`else
    // Low address bits are dropped so a jr always lands on a word boundary
    assign jr_pc   = jr_target & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign jr_trap = 1'b0;
`endif

    // Redirect-applied next PC; the reserved kind falls through to sequential
    always_comb begin
        next_pc = seq_pc;
        if (redirect_valid) begin
            case (redirect_kind)
                BR:   next_pc = seq_pc + branch_off;
                J:    next_pc = {seq_pc[ADDR_W-1:ADDR_W-4], jump_target, 2'b00};
                JR:   next_pc = jr_pc;
                RSVD: next_pc = seq_pc;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch-stage controller. Loads the external programcounter,
//                fetches each instruction over a req/ack port, holds it for
//                decode and applies sequential, branch, jump, jr and halt.
//                Optional feature macro: PC_SEQUENCER_MISALIGN_TRAP_EN
//                (misaligned jr traps to TRAP_VECTOR with a one-cycle pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
   ,parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 32'h0000_0080
`endif
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_d,
    output logic              pc_we,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [15:0]       branch_imm,
    input  logic [25:0]       jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              halt,
    output logic              halted,
    output logic              trap
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] redir_pc;
    logic              jr_trap;
    logic              accept;
    logic              advance;

    pc_next_calc
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    #(
        .TRAP_VECTOR (TRAP_VECTOR)
    )
`endif
    u_next (
        .fetch_pc       (fetch_pc),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .branch_imm     (branch_imm),
        .jump_target    (jump_target),
        .jr_target      (jr_target),
        .seq_pc         (seq_pc),
        .next_pc        (redir_pc),
        .jr_trap        (jr_trap)
    );

    // State-decoded outputs; imem_req falls as soon as reset forces INIT
    assign imem_addr   = pc_q;
    assign imem_req    = (state == ST_REQ) || (state == ST_WAIT);
    assign accept      = imem_req && imem_ack;
    assign advance     = (state == ST_DELIVER) && !stall;
    assign instr_valid = (state == ST_DELIVER);
    assign halted      = (state == ST_HALTED);
    // INIT load is suppressed while reset is still held
    assign pc_we       = (reset_n && (state == ST_INIT)) || advance;
    assign trap        = advance && !halt && jr_trap;

    // PC load value: reset vector by default, next PC on DELIVER exit
    always_comb begin
        pc_d = RESET_VECTOR;
        if (advance) begin
            pc_d = halt ? seq_pc : redir_pc;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    state_nxt = ST_REQ;
            ST_REQ:     state_nxt = imem_ack ? ST_DELIVER : ST_WAIT;
            ST_WAIT:    state_nxt = imem_ack ? ST_DELIVER : ST_WAIT;
            ST_DELIVER: begin
                if (!stall) begin
                    state_nxt = halt ? ST_HALTED : ST_REQ;
                end
            end
            ST_HALTED:  state_nxt = ST_HALTED;
            default:    state_nxt = ST_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture instruction word and its address on the accepting ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr    <= 32'd0;
            fetch_pc <= '0;
        end else if (accept) begin
            instr    <= imem_rdata;
            fetch_pc <= pc_q;
        end
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that sequences the external `programcounter` register and the instruction-memory read port. It drives the program counter's load value and write enable, requests each instruction with a req/ack handshake, and presents it to decode. Sequential PC+4, branch, jump and jump-register redirects, decode stalls and halt are all applied from here. It sits between `programcounter`, instruction memory and the decode stage in InstructionFetch.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, 32'h0000_0080: misaligned-jr target; used only with the trap feature.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc_q` in 32: current value of the `programcounter` register.
- `pc_d` out 32: load value for `programcounter`.
- `pc_we` out 1: load enable for `programcounter`; the register updates on the next `clk` edge.
- `imem_req` out 1: instruction read request.
- `imem_addr` out 32: read address; always equal to `pc_q`.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: latched instruction to decode.
- `fetch_pc` out 32: address of `instr`.
- `instr_valid` out 1: `instr` and `fetch_pc` are valid.
- `stall` in 1: decode cannot accept; hold the current instruction.
- `redirect_valid` in 1: decode requests a non-sequential next PC.
- `redirect_kind` in 2: 00 = branch, 01 = jump, 10 = jr, 11 = reserved.
- `branch_imm` in 16: signed branch word offset.
- `jump_target` in 26: J-format target field.
- `jr_target` in 32: register target for jr.
- `halt` in 1: stop fetching after the current instruction.
- `halted` out 1: sequencer has stopped.
- `trap` out 1: one-cycle pulse on a misaligned jr (trap feature only).

## Operation
- FSM states: INIT, REQ, WAIT, DELIVER, HALTED.
- **INIT** (entered from reset): `pc_d` = RESET_VECTOR, `pc_we` = 1 for one cycle, then → REQ.
- **REQ**: `imem_req` = 1.
  - `imem_ack` = 1: latch `imem_rdata` → `instr` and `pc_q` → `fetch_pc`, then → DELIVER.
  - Otherwise → WAIT.
- **WAIT**: `imem_req` held at 1 and `imem_addr` held stable; on `imem_ack` latch as in REQ, then → DELIVER.
- **DELIVER**: `instr_valid` = 1.
  - While `stall` = 1: remain in DELIVER, hold `instr`, `fetch_pc` and `instr_valid`; `pc_we` = 0; redirect inputs are ignored.
  - When `stall` = 0: `pc_we` = 1 with `pc_d` = next PC, then → REQ, or → HALTED if `halt` = 1.
- Next-PC priority, evaluated in the DELIVER cycle with `stall` = 0:
  - `halt`: `pc_d` = `fetch_pc` + 4 (PC is left pointing at the next instruction) and → HALTED.
  - Else `redirect_valid` with a valid kind:
    - branch: `fetch_pc` + 4 + (sign-extended `branch_imm` << 2).
    - jump: {(`fetch_pc` + 4)[31:28], `jump_target`, 2'b00}.
    - jr: `jr_target`.
  - Else, including kind 11 with `redirect_valid` = 1: `fetch_pc` + 4.
- Arithmetic: all sums are 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Branch offsets may be negative.
- **HALTED**: `halted` = 1, `pc_we` = 0, `imem_req` = 0. The only exit is reset.
- `imem_rdata` is ignored whenever `imem_ack` = 0; an `imem_ack` outside REQ/WAIT is ignored.
- Reset mid-operation (any state, including WAIT):
  - `imem_req` drops immediately and any outstanding ack is discarded.
  - Next state is INIT.
- Reset values: state = INIT, `pc_d` = RESET_VECTOR, `pc_we` = 0, `imem_req` = 0, `instr` = 0, `fetch_pc` = 0, `instr_valid` = 0, `halted` = 0, `trap` = 0.

## Timing
- `pc_we` asserts in INIT and in the DELIVER exit cycle only. The `programcounter` update is visible on `pc_q` in the following REQ cycle.
- Zero-wait memory: 2 cycles per instruction (REQ with ack, then DELIVER). Each wait cycle adds one WAIT cycle.
- First `imem_req` occurs in the 2nd cycle after `reset_n` deasserts.
- `instr_valid` rises one cycle after the accepting ack.
- Redirect and halt inputs are sampled combinationally in the DELIVER cycle; they take effect on the next `pc_q`.
- `halted` rises the cycle after the halt is accepted.

## Configuration
- Macro: `PC_SEQUENCER_MISALIGN_TRAP_EN`.
- Defined: a jr with `jr_target[1:0]` ≠ 0 loads TRAP_VECTOR instead of the target and pulses `trap` for one cycle (the DELIVER exit cycle).
- Undefined: `jr_target[1:0]` is forced to 00 and `trap` is tied to 0.

## Structure
- `pc_sequencer_pkg`: state enum, redirect-kind constants (BR, J, JR, RSVD), `ADDR_W` = 32, `PC_STEP` = 4.
- Sub-module `pc_next_calc`: combinational next-PC and misalignment detection, taking `fetch_pc`, kind, immediates and `jr_target`. The FSM stays in `pc_sequencer`.

## Test plan
- **Reset and fetch loop:** release reset with zero-wait memory → INIT loads 0; fetches at 0, 4, 8, with `instr_valid` every 2nd cycle.
- **Memory wait states:** 3 wait cycles on `fetch_pc` = 0x10 → `imem_addr` holds 0x10 for 4 cycles; `instr` equals `imem_rdata` at ack.
- **Branch, jump, jr:**
  - branch at 0x20 with imm = 0xFFFF → next fetch 0x20.
  - jump at 0x1000_0040 with target = 0x10 → next fetch 0x1000_0040.
  - jr with `jr_target` = 0x300 → next fetch 0x300.
- **Stall with simultaneous redirect:** stall for 3 cycles with `redirect_valid` asserted → `instr` held and `pc_we` = 0; redirect honoured only on the cycle `stall` falls.
- **Halt over redirect and wrap:**
  - halt and redirect together at 0x50 → `pc_q` = 0x54, `halted` = 1, no further `imem_req`.
  - sequential fetch from 0xFFFF_FFFC → next fetch 0x0.
- **Misaligned jr and mid-operation reset:**
  - jr to 0x302 → with the macro: fetch 0x80 and one `trap` pulse; without: fetch 0x300.
  - `reset_n` low during WAIT → `imem_req` = 0 immediately and fetch restarts at RESET_VECTOR.
